// File: rtl/siphash_msg_packer.sv
// SipHash front end: packs a byte stream into padded 64-bit words and paces core commands.
// Define SIPHASH_PACKER_FINALIZE_EN to issue the finalize opcode from this block.
module siphash_msg_packer (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  input  logic         core_busy,
  output logic         core_we,
  output logic [67:0]  core_cmd,
  output logic         active,
  output logic         done
);

  localparam logic [3:0] OP_K0  = 4'h0;
  localparam logic [3:0] OP_K1  = 4'h1;
  localparam logic [3:0] OP_MSG = 4'h2;
`ifdef SIPHASH_PACKER_FINALIZE_EN
  localparam logic [3:0] OP_FIN = 4'h3;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_KEY0, S_KEY1, S_FILL,
    S_ISSUE, S_WAIT, S_FIN, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [127:0]  key_q, key_d;
  logic [63:0]   word_q, word_d;
  logic [2:0]    lane_q, lane_d;
  logic [7:0]    len_q, len_d;
  logic          final_q, final_d;
  logic          pad_q, pad_d;
  logic          sent_q, sent_d;
  logic          first_q, first_d;
  logic [67:0]   cmd_q, cmd;
  logic          we;
`ifdef SIPHASH_PACKER_FINALIZE_EN
  logic          fin_q, fin_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      word_q  <= '0;
      lane_q  <= '0;
      len_q   <= '0;
      final_q <= 1'b0;
      pad_q   <= 1'b0;
      sent_q  <= 1'b0;
      first_q <= 1'b0;
      cmd_q   <= '0;
`ifdef SIPHASH_PACKER_FINALIZE_EN
      fin_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
      len_q   <= len_d;
      final_q <= final_d;
      pad_q   <= pad_d;
      sent_q  <= sent_d;
      first_q <= first_d;
      cmd_q   <= cmd;
`ifdef SIPHASH_PACKER_FINALIZE_EN
      fin_q   <= fin_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    word_d  = word_q;
    lane_d  = lane_q;
    len_d   = len_q;
    final_d = final_q;
    pad_d   = pad_q;
    sent_d  = sent_q;
    first_d = 1'b0;
    we      = 1'b0;
    cmd     = cmd_q;
`ifdef SIPHASH_PACKER_FINALIZE_EN
    fin_d   = fin_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d   = key;
          word_d  = '0;
          lane_d  = '0;
          len_d   = '0;
          final_d = 1'b0;
          pad_d   = 1'b0;
          sent_d  = 1'b0;
`ifdef SIPHASH_PACKER_FINALIZE_EN
          fin_d   = 1'b0;
`endif
          state_d = S_KEY0;
        end
      end
      S_KEY0: begin
        if (!core_busy) begin
          we      = 1'b1;
          cmd     = {OP_K0, key_q[63:0]};
          state_d = S_KEY1;
        end
      end
      S_KEY1: begin
        if (!core_busy) begin
          we      = 1'b1;
          cmd     = {OP_K1, key_q[127:64]};
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (in_valid) begin
          word_d[{lane_q, 3'b000} +: 8] = in_data;
          lane_d = lane_q + 3'd1;
          len_d  = len_q + 8'd1;
          // a full last word needs a separate length-only word
          if (in_last) begin
            if (lane_q == 3'd7) begin
              pad_d = 1'b1;
            end else begin
              word_d[63:56] = len_d;
              final_d = 1'b1;
            end
          end
          if (lane_q == 3'd7 || in_last) state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!core_busy) begin
          we      = 1'b1;
          cmd     = {OP_MSG, word_q};
          word_d  = '0;
          lane_d  = '0;
          sent_d  = final_q;
          first_d = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // busy lags the strobe by one cycle
        if (!first_q && !core_busy) begin
          if (sent_q) begin
            state_d = S_FIN;
          end else if (pad_q) begin
            word_d  = {len_q, 56'h0};
            final_d = 1'b1;
            pad_d   = 1'b0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_FIN: begin
`ifdef SIPHASH_PACKER_FINALIZE_EN
        if (fin_q) begin
          state_d = S_DONE;
        end else if (!core_busy) begin
          we    = 1'b1;
          cmd   = {OP_FIN, 64'h0};
          fin_d = 1'b1;
        end
`else
        state_d = S_DONE;
`endif
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign core_we  = we;
  assign core_cmd = cmd;
  assign in_ready = (state_q == S_FILL);
  assign active   = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule
